// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame length, host-TX states, default timings.
// Also used by the receive-side decoder.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_BITS,
    ST_ACK,
    ST_WAIT_REL
  } ps2_tx_state_e;

  // 100 us clock-low hold
  function automatic int inhibit_cycles(input int clk_hz);
    return clk_hz / 10_000;
  endfunction

  // 15 ms request-to-send to end-of-ACK budget
  function automatic int timeout_cycles(input int clk_hz);
    return (clk_hz / 1000) * 15;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for PS2 clk/data with a falling-edge strobe on clk.
// The strobe is combinational from registered state: pin-to-strobe is 2 cycles.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_o,
  output logic data_o,
  output logic clk_fe_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Idle bus is high; resetting to 1 avoids a false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_o    = clk_sync_q[1];
  assign data_o   = data_sync_q[1];
  assign clk_fe_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with ACK capture and timeout.
// Drives open-drain enables only; tristate buffers live at the board top.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = inhibit_cycles(CLK_FREQ_HZ),
  parameter int TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ_HZ)
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PRE = (INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0;

  localparam logic [ICW-1:0] I_LAST = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [ICW-1:0] I_PRE  = ICW'(PRE);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e state_q, state_d;
  logic [ICW-1:0] cnt_q, cnt_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     frame_q, frame_d;
  logic           clk_oe_q, clk_oe_d;
  logic           data_oe_q, data_oe_d;
  logic           ack_q, ack_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic clk_s, data_s, clk_fe;
  logic tmo_run, tmo_hit;

  ps2_line_sync u_sync (
    .clk_i      (sys_clk),
    .rst_i      (rst),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .clk_o      (clk_s),
    .data_o     (data_s),
    .clk_fe_o   (clk_fe)
  );

  assign tmo_run = state_q inside {ST_RTS, ST_BITS, ST_ACK, ST_WAIT_REL};
  assign tmo_hit = tmo_run && (tmo_q == T_LAST);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (tmo_run) tmo_d = tmo_q + TCW'(1);

    unique case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_d = '0;
          cnt_d     = '0;
          ack_d     = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d     = cnt_q + ICW'(1);
        data_oe_d = (cnt_q >= I_PRE);
        if (cnt_q == I_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          tmo_d     = '0;
          state_d   = ST_RTS;
        end
      end
      ST_RTS, ST_BITS: begin
        // Stop bit is a 1, so shifting in ones releases the line.
        if (clk_fe) begin
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b1, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (state_q == ST_RTS) state_d = ST_BITS;
          else if (bit_cnt_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fe) begin
          ack_d     = ~data_s;
          bit_cnt_d = 4'(FRAME_BITS);
          state_d   = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit) begin
      state_d   = ST_IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      ack_d     = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model,
// frames checked against start/LSB-first/odd-parity/stop built from the byte.
module tb_ps2_host_tx;

  localparam int INHIB = 2000;
  localparam int TMO   = 4000;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, ack_ok, err;
  logic       clk_oe, data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pin, ps2_data_pin;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, hs_cnt = 0;
  int run = 0, last_run = 0, fall_cyc = 0, err_cyc = 0;
  logic clk_oe_prev = 1'b0;
  bit tog = 0;

  always #5 clk = ~clk;

  assign ps2_clk_pin  = ~(clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ    (100_000_000),
    .INHIBIT_CYCLES (INHIB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk     (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_pin),
    .ps2_data_in (ps2_data_pin),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err)
  );

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (tx_valid && tx_ready && !rst) hs_cnt++;
    if (clk_oe) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (clk_oe_prev && !clk_oe) fall_cyc = cyc;
    clk_oe_prev = clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keyboard: wait for clock release after inhibit, then clock npulse times.
  task automatic device(input bit ack, input int npulse,
                        output logic [10:0] samp, output bit ok);
    int n;
    bit saw_low;
    samp = '1;
    n = 0;
    while (ps2_clk_pin && n < 200) begin tick(); n++; end
    saw_low = !ps2_clk_pin;
    while (!ps2_clk_pin && n < INHIB + 400) begin tick(); n++; end
    ok = saw_low && ps2_clk_pin;
    if (!ok) return;
    samp[0] = ps2_data_pin;
    repeat (20) tick();
    for (int p = 1; p <= npulse; p++) begin
      if (p == 11) begin
        dev_data_low = ack;
        repeat (HALF / 2) tick();
      end
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      tick();
      if (p <= 10) samp[p] = ps2_data_pin;
      repeat (HALF - 1) tick();
    end
    dev_data_low = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input bit hold);
    logic [10:0] samp, exp;
    bit ok;
    int d0, e0, h0;
    exp = {1'b1, 1'(($countones(b) % 2) == 0), b, 1'b0};
    d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt;
    chk("pre_ready", tx_ready, 1);
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    chk("hs_ready", tx_ready, 0);
    chk("hs_clk_oe", clk_oe, 1);
    chk("hs_busy", busy, 1);
    if (!hold) tx_valid = 1'b0;
    tog = hold;
    fork
      begin
        device(ack, 11, samp, ok);
        tog = 0;
        tx_valid = 1'b0;
      end
      begin
        while (tog) begin
          tick();
          tx_data = 8'($urandom);
        end
      end
    join
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    chk("rts_seen", ok, 1);
    chk("frame", samp, exp);
    chk("done_pulses", done_cnt - d0, 1);
    chk("err_pulses", err_cnt - e0, 0);
    chk("ack_ok", ack_ok, ack);
    chk("clk_rel", clk_oe, 0);
    chk("data_rel", data_oe, 0);
    chk("inhibit_len", last_run, INHIB);
    repeat (10) tick();
    chk("ack_hold", ack_ok, ack);
    chk("handshakes", hs_cnt - h0, 1);
    chk("done_single", done_cnt - d0, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] samp;
    bit ok;
    int d0, e0;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ack", ack_ok, 0);

    xfer(8'hED, 1'b1, 1'b0);
    xfer(8'h01, 1'b1, 1'b0);
    xfer(8'h00, 1'b1, 1'b0);
    xfer(8'hFF, 1'b1, 1'b0);
    xfer(8'($urandom), 1'b0, 1'b0);

    // Silent device: only the timeout can end this transfer.
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    device(1'b0, 0, samp, ok);
    chk("tmo_rts", ok, 1);
    for (int i = 0; i < TMO + 100 && err_cnt == e0; i++) tick();
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_done", done_cnt - d0, 0);
    chk("tmo_cycles", err_cyc - fall_cyc, TMO);
    chk("tmo_clk_oe", clk_oe, 0);
    chk("tmo_data_oe", data_oe, 0);
    chk("tmo_ready", tx_ready, 1);
    chk("tmo_ack", ack_ok, 0);
    repeat (20) tick();
    chk("tmo_err_once", err_cnt - e0, 1);

    // Reset in the middle of the data bits.
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    device(1'b1, 6, samp, ok);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_clk_oe", clk_oe, 0);
    chk("mid_data_oe", data_oe, 0);
    chk("mid_ready", tx_ready, 1);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    repeat (50) tick();
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_no_err", err_cnt - e0, 0);
    xfer(8'hF4, 1'b1, 1'b0);

    xfer(8'($urandom), 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) xfer(8'($urandom), 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
